sargantana_icache_refill: RTL

//  Refill engine of the instruction cache: takes a miss (tag + set index), requests the line from L2,

---
 rtl/sargantana_icache_refill.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sargantana_icache_refill.sv
// Icache refill engine: accepts a miss, fetches a 4-beat line from L2, picks a victim way
// and issues a single-cycle tag/data/valid write into the way arrays.
module sargantana_icache_refill #(
  parameter int N_WAY  = 4,
  parameter int TAG_W  = 20,
  parameter int IDX_W  = 6,
  parameter int BEAT_W = 128
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     miss_valid_i,
  output logic                     miss_ready_o,
  input  logic [TAG_W-1:0]         miss_tag_i,
  input  logic [IDX_W-1:0]         miss_idx_i,
  input  logic [N_WAY-1:0]         way_valid_bits_i,
  input  logic                     flush_i,
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic [TAG_W+IDX_W-1:0]   mem_req_addr_o,
  input  logic                     mem_rsp_valid_i,
  input  logic [BEAT_W-1:0]        mem_rsp_data_i,
  input  logic                     mem_rsp_err_i,
  output logic                     wr_en_o,
  output logic [N_WAY-1:0]         wr_way_o,
  output logic [IDX_W-1:0]         wr_idx_o,
  output logic [TAG_W-1:0]         wr_tag_o,
  output logic [4*BEAT_W-1:0]      wr_data_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int RR_W = (N_WAY > 1) ? $clog2(N_WAY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DRAIN,
    S_WRITE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [TAG_W-1:0]    r_tag;
  logic [IDX_W-1:0]    r_idx;
  logic [N_WAY-1:0]    r_way;
  logic                r_use_rr;
  logic                r_err;
  logic [1:0]          r_cnt;
  logic [RR_W-1:0]     r_rr;
  logic [4*BEAT_W-1:0] r_line;

  logic [N_WAY-1:0]    w_victim;
  logic                w_victim_rr;
  logic                w_last_beat;
  logic                w_err_now;
  logic                w_beat_take;

  // Lowest-index invalid way wins; a fully valid set falls back to round-robin.
  always_comb begin
    w_victim    = '0;
    w_victim_rr = 1'b1;
    for (int i = N_WAY - 1; i >= 0; i--) begin
      if (!way_valid_bits_i[i]) begin
        w_victim    = '0;
        w_victim[i] = 1'b1;
        w_victim_rr = 1'b0;
      end
    end
    if (w_victim_rr) begin
      w_victim = N_WAY'(1) << r_rr;
    end
  end

  assign w_last_beat = mem_rsp_valid_i && (r_cnt == 2'd3);
  assign w_err_now   = r_err | mem_rsp_err_i;
  assign w_beat_take = mem_rsp_valid_i && ((r_state == S_RESP) || (r_state == S_DRAIN));

  always_comb begin
    w_next          = r_state;
    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    wr_en_o         = 1'b0;
    done_o          = 1'b0;
    err_o           = 1'b0;
    case (r_state)
      S_IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) w_next = S_REQ;
      end
      S_REQ: begin
        mem_req_valid_o = 1'b1;
        if (flush_i) w_next = mem_req_ready_i ? S_DRAIN : S_IDLE;
        else if (mem_req_ready_i) w_next = S_RESP;
      end
      S_RESP: begin
        if (flush_i) begin
          w_next = w_last_beat ? S_IDLE : S_DRAIN;
        end else if (w_last_beat) begin
          w_next = w_err_now ? S_IDLE : S_WRITE;
          err_o  = w_err_now;
        end
      end
      S_DRAIN: begin
        if (w_last_beat) w_next = S_IDLE;
      end
      S_WRITE: begin
        wr_en_o = 1'b1;
        done_o  = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_tag    <= '0;
      r_idx    <= '0;
      r_way    <= '0;
      r_use_rr <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_rr     <= '0;
      r_line   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && miss_valid_i) begin
        r_tag    <= miss_tag_i;
        r_idx    <= miss_idx_i;
        r_way    <= w_victim;
        r_use_rr <= w_victim_rr;
        r_err    <= 1'b0;
        r_cnt    <= '0;
      end
      // Drained beats still advance the counter so the line boundary is tracked.
      if (w_beat_take) begin
        r_cnt <= r_cnt + 2'd1;
        if (r_state == S_RESP) begin
          r_line[int'(r_cnt)*BEAT_W +: BEAT_W] <= mem_rsp_data_i;
          r_err <= w_err_now;
        end
      end
      if ((r_state == S_WRITE) && r_use_rr) begin
        r_rr <= r_rr + RR_W'(1);
      end
    end
  end

  assign mem_req_addr_o = {r_tag, r_idx};
  assign wr_way_o       = r_way;
  assign wr_idx_o       = r_idx;
  assign wr_tag_o       = r_tag;
  assign wr_data_o      = r_line;

endmodule
